// File: rtl/mux_16t4_tx_ctrl.sv
// Word sequencer for the 16:4 mux din: IDLE -> TRAIN (TRAIN_LEN training words) -> DATA (framed user words).
// Accepted words reach mux_din on the accepting edge; s_ready is low outside DATA and in every sync slot.
module mux_16t4_tx_ctrl #(
  parameter int unsigned TRAIN_LEN = 64,
  parameter int unsigned FRAME_LEN = 32,
  parameter logic [15:0] TRAIN_PAT = 16'h5555,
  parameter logic [15:0] SYNC_WORD = 16'hF0F0,
  parameter logic [15:0] IDLE_WORD = 16'h0F0F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        retrain,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] mux_din,
  output logic        link_up,
  output logic        train_busy,
  output logic [15:0] word_cnt
);

  localparam logic [15:0] TR_LAST  = 16'(TRAIN_LEN - 1);
  localparam logic [7:0]  FRM_LAST = 8'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DATA  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] tr_cnt_q, tr_cnt_d;
  logic [7:0]  frm_cnt_q, frm_cnt_d;
  logic [15:0] mux_din_q, mux_din_d;
  logic        link_up_q, link_up_d;
  logic        train_busy_q, train_busy_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic        xfer;

  // Ready comes from registered state only; en qualifies the transfer so a disabled link accepts nothing.
  assign s_ready = (state_q == ST_DATA) && (frm_cnt_q != 8'd0);
  assign xfer    = en && s_valid && s_ready;

  always_comb begin
    state_d      = state_q;
    tr_cnt_d     = tr_cnt_q;
    frm_cnt_d    = frm_cnt_q;
    mux_din_d    = 16'h0000;
    word_cnt_d   = word_cnt_q;
    link_up_d    = en && (state_q == ST_DATA);
    train_busy_d = en && (state_q == ST_TRAIN);

    if (xfer) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end

    if (!en) begin
      state_d   = ST_IDLE;
      tr_cnt_d  = 16'd0;
      frm_cnt_d = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_TRAIN;
          tr_cnt_d = 16'd0;
        end
        ST_TRAIN: begin
          mux_din_d = TRAIN_PAT;
          if (retrain) begin
            tr_cnt_d = 16'd0;
          end else if (tr_cnt_q == TR_LAST) begin
            state_d   = ST_DATA;
            tr_cnt_d  = 16'd0;
            frm_cnt_d = 8'd0;
          end else begin
            tr_cnt_d = tr_cnt_q + 16'd1;
          end
        end
        ST_DATA: begin
          if (frm_cnt_q == 8'd0) begin
            mux_din_d = SYNC_WORD;
          end else if (xfer) begin
            mux_din_d = s_data;
          end else begin
            mux_din_d = IDLE_WORD;
          end
          frm_cnt_d = (frm_cnt_q == FRM_LAST) ? 8'd0 : frm_cnt_q + 8'd1;
          // The word accepted alongside retrain is already in mux_din_d; only the sequencing restarts.
          if (retrain) begin
            state_d   = ST_TRAIN;
            tr_cnt_d  = 16'd0;
            frm_cnt_d = 8'd0;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          tr_cnt_d  = 16'd0;
          frm_cnt_d = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tr_cnt_q     <= 16'd0;
      frm_cnt_q    <= 8'd0;
      mux_din_q    <= 16'h0000;
      link_up_q    <= 1'b0;
      train_busy_q <= 1'b0;
      word_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      tr_cnt_q     <= tr_cnt_d;
      frm_cnt_q    <= frm_cnt_d;
      mux_din_q    <= mux_din_d;
      link_up_q    <= link_up_d;
      train_busy_q <= train_busy_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  assign mux_din    = mux_din_q;
  assign link_up    = link_up_q;
  assign train_busy = train_busy_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_mux_16t4_tx_ctrl.sv
// Directed bench for mux_16t4_tx_ctrl with default parameters (64 training words, 32-word frames).
module tb_mux_16t4_tx_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        retrain;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] mux_din;
  logic        link_up;
  logic        train_busy;
  logic [15:0] word_cnt;

  int total = 0;
  int bad   = 0;
  int pos   = 0;

  mux_16t4_tx_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .retrain    (retrain),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .mux_din    (mux_din),
    .link_up    (link_up),
    .train_busy (train_busy),
    .word_cnt   (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; retrain = 1'b0; s_data = 16'h0; s_valid = 1'b0;
    #12;
    total++;
    if (mux_din !== 16'h0 || link_up !== 1'b0 || train_busy !== 1'b0 || word_cnt !== 16'h0 || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset: din=%h up=%b busy=%b cnt=%h rdy=%b want 0000/0/0/0000/0",
               mux_din, link_up, train_busy, word_cnt, s_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Expects: one zero word, 64 training words, then a SYNC word with link_up.
  task automatic check_training(input string tag);
    step();
    total++;
    if (mux_din !== 16'h0000 || train_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle_word: din=%h busy=%b want 0000/0", tag, mux_din, train_busy);
    end
    check_train_words(tag);
  endtask

  task automatic check_train_words(input string tag);
    for (int i = 0; i < 64; i++) begin
      step();
      total++;
      if (mux_din !== 16'h5555 || train_busy !== 1'b1 || link_up !== 1'b0 || s_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s_train[%0d]: din=%h busy=%b up=%b rdy=%b want 5555/1/0/0",
                 tag, i, mux_din, train_busy, link_up, s_ready);
      end
    end
    step();
    total++;
    if (mux_din !== 16'hF0F0 || link_up !== 1'b1 || train_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_first_sync: din=%h up=%b busy=%b want f0f0/1/0", tag, mux_din, link_up, train_busy);
    end
    pos = 1;
  endtask

  task automatic test_bringup();
    en = 1'b1;
    check_training("bringup");
    for (int i = 0; i < 31; i++) begin
      step();
      total++;
      if (mux_din !== 16'h0F0F || link_up !== 1'b1) begin
        bad++;
        $display("FAIL bringup_idle[%0d]: din=%h up=%b want 0f0f/1", i, mux_din, link_up);
      end
    end
    step();
    total++;
    if (mux_din !== 16'hF0F0) begin
      bad++;
      $display("FAIL bringup_second_sync: din=%h want f0f0", mux_din);
    end
    pos = 1;
  endtask

  task automatic test_stream();
    logic [15:0] nxt;
    logic        exp_rdy;
    nxt = 16'h0001;
    s_valid = 1'b1;
    for (int i = 0; i < 63; i++) begin
      s_data  = nxt;
      exp_rdy = (pos != 0);
      total++;
      if (s_ready !== exp_rdy) begin
        bad++;
        $display("FAIL stream_ready[%0d]: rdy=%b want %b", i, s_ready, exp_rdy);
      end
      step();
      total++;
      if (exp_rdy) begin
        if (mux_din !== nxt) begin
          bad++;
          $display("FAIL stream_word[%0d]: din=%h want %h", i, mux_din, nxt);
        end
        nxt = nxt + 16'd1;
      end else if (mux_din !== 16'hF0F0) begin
        bad++;
        $display("FAIL stream_sync[%0d]: din=%h want f0f0", i, mux_din);
      end
      pos = (pos + 1) % 32;
    end
    s_valid = 1'b0;
    total++;
    if (word_cnt !== 16'd62) begin
      bad++;
      $display("FAIL stream_count: cnt=%0d want 62", word_cnt);
    end
  endtask

  task automatic test_retrain_in_data();
    logic [15:0] exp_w;
    while (pos != 5) begin
      exp_w = (pos == 0) ? 16'hF0F0 : 16'h0F0F;
      step();
      total++;
      if (mux_din !== exp_w) begin
        bad++;
        $display("FAIL retrain_pre[%0d]: din=%h want %h", pos, mux_din, exp_w);
      end
      pos = (pos + 1) % 32;
    end
    s_valid = 1'b1; s_data = 16'hABCD; retrain = 1'b1;
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL retrain_ready: rdy=%b want 1", s_ready);
    end
    step();
    s_valid = 1'b0; retrain = 1'b0;
    total++;
    if (mux_din !== 16'hABCD || link_up !== 1'b1 || word_cnt !== 16'd63) begin
      bad++;
      $display("FAIL retrain_inflight: din=%h up=%b cnt=%0d want abcd/1/63", mux_din, link_up, word_cnt);
    end
    check_train_words("retrain");
  endtask

  task automatic test_en_drop();
    retrain = 1'b1;
    step();
    retrain = 1'b0;
    total++;
    if (mux_din !== 16'h0F0F) begin
      bad++;
      $display("FAIL endrop_pre: din=%h want 0f0f", mux_din);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (mux_din !== 16'h5555) begin
        bad++;
        $display("FAIL endrop_partial[%0d]: din=%h want 5555", i, mux_din);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (mux_din !== 16'h0000 || train_busy !== 1'b0 || link_up !== 1'b0) begin
        bad++;
        $display("FAIL endrop_idle[%0d]: din=%h busy=%b up=%b want 0000/0/0", i, mux_din, train_busy, link_up);
      end
    end
    en = 1'b1;
    check_training("reenable");
  endtask

  task automatic test_async_reset();
    s_valid = 1'b1; s_data = 16'h1234;
    step();
    s_valid = 1'b0;
    total++;
    if (mux_din !== 16'h1234 || word_cnt !== 16'd64) begin
      bad++;
      $display("FAIL areset_pre: din=%h cnt=%0d want 1234/64", mux_din, word_cnt);
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (mux_din !== 16'h0 || link_up !== 1'b0 || word_cnt !== 16'h0 || train_busy !== 1'b0 || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL areset: din=%h up=%b cnt=%h busy=%b rdy=%b want 0000/0/0000/0/0",
               mux_din, link_up, word_cnt, train_busy, s_ready);
    end
    en = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    int n;
    int cyc;
    en = 1'b1; s_valid = 1'b1; s_data = 16'h0007;
    cyc = 0;
    while (link_up !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    total++;
    if (link_up !== 1'b1) begin
      bad++;
      $display("FAIL wrap_linkup: up=%b want 1 within 200 cycles", link_up);
    end
    n = 0; cyc = 0;
    while (n < 65535 && cyc < 80000) begin
      if (s_ready === 1'b1) n++;
      step();
      cyc++;
    end
    total++;
    if (n != 65535 || word_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_full: cnt=%h transfers=%0d want ffff/65535", word_cnt, n);
    end
    cyc = 0;
    while (s_ready !== 1'b1 && cyc < 4) begin
      step();
      cyc++;
    end
    step();
    s_valid = 1'b0;
    total++;
    if (word_cnt !== 16'h0000) begin
      bad++;
      $display("FAIL wrap_zero: cnt=%h want 0000", word_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_stream();
    test_retrain_in_data();
    test_en_drop();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
